// File: rtl/modport_mem_pkg.sv
// Shared widths, word types and access decode for the 256 x 8 single-port RAM.
package modport_mem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } access_e;

    // write is only meaningful while enable is high.
    function automatic access_e decode_access(input logic enable, input logic write);
        if (!enable) begin
            return ACC_IDLE;
        end
        return write ? ACC_WRITE : ACC_READ;
    endfunction

endpackage

// File: rtl/modport_mem_array.sv
// Storage array with synchronous write, synchronous full clear and a registered read port.
module modport_mem_array
    import modport_mem_pkg::*;
#(
    parameter int ADDR_W = modport_mem_pkg::ADDR_W,
    parameter int DATA_W = modport_mem_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH_L = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH_L];

    // Clear overrides any access presented in the same cycle.
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < DEPTH_L; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    // Read register holds across writes and idles; no write-through.
    always_ff @(posedge clock) begin
        if (clear) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[addr];
        end
    end

endmodule

// File: rtl/modport_mem.sv
// Single-port synchronous RAM: one access per cycle, reads appear on data_out one edge later.
// No handshake: every cycle with enable=1 is an accepted access, never stalled.
module modport_mem
    import modport_mem_pkg::*;
#(
    parameter int ADDR_W = modport_mem_pkg::ADDR_W,
    parameter int DATA_W = modport_mem_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              enable,
    input  logic              write,
    output logic [DATA_W-1:0] data_out
);

    access_e           access;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;

    always_comb begin
        access = decode_access(enable, write);
        wr_en  = (access == ACC_WRITE);
        rd_en  = (access == ACC_READ);
    end

    modport_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clock   (clock),
        .clear   (reset),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .addr    (address),
        .wr_data (data_in),
        .rd_data (rd_data)
    );

    // rd_data is already a flop, so data_out has no combinational path from inputs.
    assign data_out = rd_data;

endmodule

// File: tb/tb_modport_mem.sv
// Directed bench for modport_mem: reset, write/read, sweep, idle hold, boundaries, mid-run reset.
module tb_modport_mem;
    import modport_mem_pkg::*;

    localparam int W = DATA_W;

    logic  clock;
    logic  reset;
    addr_t address;
    data_t data_in;
    logic  enable;
    logic  write;
    data_t data_out;

    int vec_count   = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];

    modport_mem dut (
        .clock    (clock),
        .reset    (reset),
        .address  (address),
        .data_in  (data_in),
        .enable   (enable),
        .write    (write),
        .data_out (data_out)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input data_t got, input data_t exp);
        vec_count++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Drivers: called at edge+1, return at the next edge+1.
    task automatic idle_cycle();
        enable  = 1'b0;
        write   = 1'($urandom_range(0, 1));
        address = addr_t'($urandom_range(0, 255));
        data_in = data_t'($urandom_range(0, 255));
        @(posedge clock);
        #1;
    endtask

    task automatic write_word(input addr_t a, input data_t d);
        enable  = 1'b1;
        write   = 1'b1;
        address = a;
        data_in = d;
        @(posedge clock);
        #1;
    endtask

    task automatic read_word(input string tag, input addr_t a, input data_t exp);
        enable  = 1'b1;
        write   = 1'b0;
        address = a;
        data_in = 8'h00;
        exp_q.push_back(exp);
        @(posedge clock);
        #1;
        check_eq(tag, data_out, exp_q.pop_front());
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        write   = 1'b0;
        address = '0;
        data_in = '0;

        // Reset check
        @(posedge clock);
        @(posedge clock);
        #1;
        check_eq("reset_dout", data_out, 8'h00);
        reset = 1'b0;
        read_word("reset_rd_00", 8'h00, 8'h00);
        read_word("reset_rd_7f", 8'h7F, 8'h00);
        read_word("reset_rd_ff", 8'hFF, 8'h00);

        // Basic write/read; data_out must not follow the write
        write_word(8'h10, 8'hA5);
        check_eq("wr_no_thru", data_out, 8'h00);
        read_word("basic_rd_10", 8'h10, 8'hA5);
        write_word(8'h11, 8'h5C);
        check_eq("wr_hold", data_out, 8'hA5);

        // Back-to-back sweep
        for (int i = 0; i < 256; i++) begin
            write_word(addr_t'(i), data_t'(i) ^ 8'h5A);
        end
        for (int i = 0; i < 256; i++) begin
            read_word("sweep_rd", addr_t'(i), data_t'(i) ^ 8'h5A);
        end

        // Idle hold
        write_word(8'h20, 8'h3C);
        read_word("idle_pre_rd", 8'h20, 8'h3C);
        for (int i = 0; i < 5; i++) begin
            idle_cycle();
            check_eq("idle_hold", data_out, 8'h3C);
        end
        read_word("idle_post_rd", 8'h20, 8'h3C);

        // Overwrite and boundaries
        write_word(8'hFF, 8'h11);
        write_word(8'hFF, 8'hEE);
        write_word(8'h00, 8'h01);
        read_word("bound_rd_ff", 8'hFF, 8'hEE);
        read_word("bound_rd_00", 8'h00, 8'h01);
        read_word("bound_rd_fe", 8'hFE, 8'hA4);
        write_word(8'h01, 8'h77);
        read_word("raw_rd_01", 8'h01, 8'h77);

        // Reset mid-operation with a write presented on the reset edge
        write_word(8'h40, 8'h99);
        read_word("mid_pre_rd", 8'h40, 8'h99);
        reset   = 1'b1;
        enable  = 1'b1;
        write   = 1'b1;
        address = 8'h41;
        data_in = 8'h77;
        @(posedge clock);
        #1;
        check_eq("mid_rst_dout", data_out, 8'h00);
        reset = 1'b0;
        read_word("mid_rd_40", 8'h40, 8'h00);
        read_word("mid_rd_41", 8'h41, 8'h00);
        read_word("mid_rd_20", 8'h20, 8'h00);

        enable = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
